// File: rtl/tag_match_pkg.sv
// Shared definitions for the tag_match_ctl block: FSM state encoding,
// default geometry and the address field split (index low, tag high).
package tag_match_pkg;

    localparam int IDX_W_DEF  = 5;
    localparam int TAG_W_DEF  = 6;
    localparam int ADDR_W_DEF = IDX_W_DEF + TAG_W_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        FILL  = 3'd2,
        RESP  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    // Index field of a lookup address (default geometry).
    function automatic logic [IDX_W_DEF-1:0] addr_index(input logic [ADDR_W_DEF-1:0] addr);
        return addr[IDX_W_DEF-1:0];
    endfunction

    // Tag field of a lookup address (default geometry).
    function automatic logic [TAG_W_DEF-1:0] addr_tag(input logic [ADDR_W_DEF-1:0] addr);
        return addr[ADDR_W_DEF-1:IDX_W_DEF];
    endfunction

endpackage

// File: rtl/tag_match_store.sv
// Tag/valid register array: asynchronous read, one write port that also
// sets the valid bit, one per-entry valid clear, and clear-all on reset.
// Optional macro TAG_PARITY_EN adds an even-parity bit per entry.
module tag_match_store
    import tag_match_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
`ifdef TAG_PARITY_EN
    output logic             rd_par,
`endif
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [TAG_W-1:0] tag_rd   [DEPTH];
    logic             valid_rd [DEPTH];
`ifdef TAG_PARITY_EN
    logic             par_rd   [DEPTH];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [TAG_W-1:0] tag_reg;
            logic             valid_reg;
`ifdef TAG_PARITY_EN
            logic             par_reg;
`endif
            // One entry: reset clears everything; a write wins over a clear.
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_reg   <= '0;
                    valid_reg <= 1'b0;
`ifdef TAG_PARITY_EN
                    par_reg   <= 1'b0;
`endif
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    tag_reg   <= wr_tag;
                    valid_reg <= 1'b1;
`ifdef TAG_PARITY_EN
                    par_reg   <= ^wr_tag;
`endif
                end else if (clr_en && (clr_idx == IDX_W'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end
            assign tag_rd[gi]   = tag_reg;
            assign valid_rd[gi] = valid_reg;
`ifdef TAG_PARITY_EN
            assign par_rd[gi]   = par_reg;
`endif
        end
    endgenerate

    assign rd_tag   = tag_rd[rd_idx];
    assign rd_valid = valid_rd[rd_idx];
`ifdef TAG_PARITY_EN
    assign rd_par   = par_rd[rd_idx];
`endif

endmodule

// File: rtl/tag_match_ctl.sv
// Tag store sequencer in front of a 6-bit equality comparator: latches a
// lookup, presents stored/request tags to the comparator, runs a fill on a
// miss and a 32-cycle whole-store invalidate.
// Optional macro TAG_PARITY_EN adds per-entry parity and a sticky perr output.
module tag_match_ctl
    import tag_match_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W+TAG_W-1:0] req_addr,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [IDX_W-1:0]       resp_index,
    output logic                   fill_req,
    output logic [IDX_W+TAG_W-1:0] fill_addr,
    input  logic                   fill_ack,
    input  logic                   inval,
    output logic                   busy,
    output logic [TAG_W-1:0]       cmp_a,
    output logic [TAG_W-1:0]       cmp_b,
    output logic                   cmp_enb,
`ifdef TAG_PARITY_EN
    output logic                   perr,
`endif
    input  logic                   cmp_eq
);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [IDX_W-1:0] flush_cnt_reg;
    logic             pend_reg;
    logic             ready_reg;
    logic             resp_valid_reg;
    logic             resp_hit_reg;
    logic             fill_req_reg;
    logic             busy_reg;
    logic             par_err;
    logic             wr_en;
    logic             clr_en;
`ifdef TAG_PARITY_EN
    logic             rd_par;
    logic             perr_reg;
`endif

    tag_match_store #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_reg),
        .rd_tag   (cmp_a),
        .rd_valid (cmp_enb),
`ifdef TAG_PARITY_EN
        .rd_par   (rd_par),
`endif
        .wr_en    (wr_en),
        .wr_idx   (idx_reg),
        .wr_tag   (tag_reg),
        .clr_en   (clr_en),
        .clr_idx  (flush_cnt_reg)
    );

    // Store write/clear strobes and the parity check of the entry under compare.
    always_comb begin
        wr_en   = (state_reg == FILL) && fill_ack;
        clr_en  = (state_reg == FLUSH);
`ifdef TAG_PARITY_EN
        par_err = cmp_enb && (rd_par != ^cmp_a);
`else
        par_err = 1'b0;
`endif
    end

    // Lookup/fill/flush sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            tag_reg        <= '0;
            flush_cnt_reg  <= '0;
            pend_reg       <= 1'b0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            fill_req_reg   <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef TAG_PARITY_EN
            perr_reg       <= 1'b0;
`endif
        end else begin
            // Invalidates arriving mid-lookup are remembered; during a flush they merge.
            if (inval && (state_reg inside {CMP, FILL, RESP}))
                pend_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (inval || pend_reg) begin
                        state_reg     <= FLUSH;
                        pend_reg      <= 1'b0;
                        flush_cnt_reg <= '0;
                        ready_reg     <= 1'b0;
                        busy_reg      <= 1'b1;
                    end else if (req_valid && ready_reg) begin
                        state_reg <= CMP;
                        idx_reg   <= req_addr[IDX_W-1:0];
                        tag_reg   <= req_addr[IDX_W +: TAG_W];
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                CMP: begin
                    if (cmp_eq && !par_err) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_hit_reg   <= 1'b1;
                    end else begin
                        state_reg    <= FILL;
                        fill_req_reg <= 1'b1;
                    end
`ifdef TAG_PARITY_EN
                    if (par_err)
                        perr_reg <= 1'b1;
`endif
                end
                FILL: begin
                    if (fill_ack) begin
                        state_reg      <= RESP;
                        fill_req_reg   <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_hit_reg   <= 1'b0;
                    end
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_hit_reg   <= 1'b0;
                    busy_reg       <= 1'b0;
                    ready_reg      <= !(pend_reg || inval);
                end
                FLUSH: begin
                    flush_cnt_reg <= flush_cnt_reg + IDX_W'(1);
                    if (flush_cnt_reg == '1) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_hit   = resp_hit_reg;
    assign resp_index = idx_reg;
    assign fill_req   = fill_req_reg;
    assign fill_addr  = {tag_reg, idx_reg};
    assign busy       = busy_reg;
    assign cmp_b      = tag_reg;
`ifdef TAG_PARITY_EN
    assign perr       = perr_reg;
`endif

endmodule

// File: tb/tb_tag_match_ctl.sv
// Directed bench for tag_match_ctl with a behavioural 93S46 comparator.
// Optional macro TAG_PARITY_EN enables the parity-error scenario.
module tb_tag_match_ctl;
    import tag_match_pkg::*;

    localparam int IDX_W = 5;
    localparam int TAG_W = 6;
    localparam int AW    = IDX_W + TAG_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic             fill_req;
    logic [AW-1:0]    fill_addr;
    logic             fill_ack;
    logic             inval;
    logic             busy;
    logic [TAG_W-1:0] cmp_a;
    logic [TAG_W-1:0] cmp_b;
    logic             cmp_enb;
    logic             cmp_eq;
`ifdef TAG_PARITY_EN
    logic             perr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Comparator model: EQ only when enabled and all six bits match.
    assign cmp_eq = cmp_enb && (cmp_a == cmp_b);

    tag_match_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_ack   (fill_ack),
        .inval      (inval),
        .busy       (busy),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_enb    (cmp_enb),
`ifdef TAG_PARITY_EN
        .perr       (perr),
`endif
        .cmp_eq     (cmp_eq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lookup: wait for ready, accept, check CMP, then hit or fill path.
    task automatic lookup(input string name, input logic [AW-1:0] addr, input bit exp_hit,
                          input bit inval_in_fill, input bit corrupt);
        int n;
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            check({name, " ready_timeout"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        tick();                         // accept edge
        req_valid = 1'b0;
        check({name, " cmp_b"}, 64'(cmp_b), 64'(addr_tag(addr)));
        check({name, " cmp_resp_low"}, 64'(resp_valid), 64'd0);
        if (corrupt) begin
`ifdef TAG_PARITY_EN
            force dut.rd_par = ~(^addr_tag(addr));
`endif
        end
        tick();                         // CMP edge
`ifdef TAG_PARITY_EN
        release dut.rd_par;
`endif
        if (exp_hit) begin
            check({name, " hit_resp"}, {62'd0, resp_valid, resp_hit}, 64'b11);
            check({name, " hit_nofill"}, 64'(fill_req), 64'd0);
            check({name, " hit_index"}, 64'(resp_index), 64'(addr_index(addr)));
        end else begin
            check({name, " fill_req"}, {52'd0, resp_valid, fill_req, 10'd0}, {52'd0, 1'b0, 1'b1, 10'd0});
            check({name, " fill_addr"}, 64'(fill_addr), 64'(addr));
            if (inval_in_fill) inval = 1'b1;
            tick();
            inval = 1'b0;
            tick();
            check({name, " fill_held"}, 64'(fill_req), 64'd1);
            fill_ack = 1'b1;
            tick();
            fill_ack = 1'b0;
            check({name, " miss_resp"}, {62'd0, resp_valid, resp_hit}, 64'b10);
            check({name, " miss_index"}, 64'(resp_index), 64'(addr_index(addr)));
        end
        tick();                         // RESP -> IDLE
        check({name, " resp_pulse_end"}, 64'(resp_valid), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({req_ready, resp_valid, resp_hit, resp_index, fill_req, fill_addr,
                    busy, cmp_a, cmp_b, cmp_enb});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        fill_ack  = 1'b0;
        inval     = 1'b0;
        tick();
        tick();
        check("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;

        lookup("first_2A5", 11'h2A5, 1'b0, 1'b0, 1'b0);
        lookup("repeat_2A5", 11'h2A5, 1'b1, 1'b0, 1'b0);
        lookup("replace_3E5", 11'h3E5, 1'b0, 1'b0, 1'b0);
        lookup("again_2A5", 11'h2A5, 1'b0, 1'b0, 1'b0);
        lookup("hit_after_refill", 11'h2A5, 1'b1, 1'b0, 1'b0);

        // Invalidate together with a request: flush wins.
        req_valid = 1'b1;
        req_addr  = 11'h3E5;
        inval     = 1'b1;
        tick();
        inval     = 1'b0;
        req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (!busy || req_ready || resp_valid) bad++;
            tick();
        end
        check("flush_busy_32", 64'(bad), 64'd0);
        check("flush_done", {62'd0, busy, req_ready}, 64'b01);
        lookup("post_flush_3E5", 11'h3E5, 1'b0, 1'b0, 1'b0);
        lookup("idx0_cold", 11'h000, 1'b0, 1'b0, 1'b0);

        // Invalidate during a fill: response first, then flush, then reset.
        lookup("inval_fill_2A5", 11'h2A5, 1'b0, 1'b1, 1'b0);
        check("pend_blocks_ready", {62'd0, req_ready, busy}, 64'b00);
        tick();
        check("pend_flush_start", {62'd0, req_ready, busy}, 64'b01);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset_mid_flush", all_outs(), 64'd0);
        reset    = 1'b0;
        fill_ack = 1'b1;
        tick();
        fill_ack = 1'b0;
        check("late_ack_ignored", {62'd0, fill_req, busy}, 64'b00);
        lookup("post_reset_2A5", 11'h2A5, 1'b0, 1'b0, 1'b0);
        lookup("post_reset_hit", 11'h2A5, 1'b1, 1'b0, 1'b0);

`ifdef TAG_PARITY_EN
        check("perr_clear", 64'(perr), 64'd0);
        lookup("parity_2A5", 11'h2A5, 1'b0, 1'b0, 1'b1);
        check("perr_set", 64'(perr), 64'd1);
        lookup("parity_refilled", 11'h2A5, 1'b1, 1'b0, 1'b0);
        check("perr_sticky", 64'(perr), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tag_match_ctl.md
Name: tag_match_ctl

Overview:
- Tag-store and sequencing stage that sits directly upstream of the 6-bit equality comparator (93S46-style part).
- Holds one 6-bit tag and one valid bit per index.
- For each lookup, drives the comparator's A/B/ENB inputs and consumes its EQ result.
- On a miss, runs a fill handshake to the memory side and installs the new tag. Also supports a whole-store invalidate sequence.

Parameters:
IDX_W, 5, index width; store depth is 2**IDX_W (32 entries).
TAG_W, 6, tag width; fixed at 6 to match the comparator; other values are unsupported.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  lookup request present.
req_ready  output  1  block can accept a request this cycle.
req_addr  input  IDX_W+TAG_W  lookup address; low IDX_W bits are the index, high TAG_W bits are the tag.
resp_valid  output  1  one-cycle pulse; the response fields are valid.
resp_hit  output  1  1 = tag matched an existing entry; 0 = miss, entry now filled.
resp_index  output  IDX_W  index of the responding lookup.
fill_req  output  1  fill request to memory; held until acknowledged.
fill_addr  output  IDX_W+TAG_W  address being filled; stable while fill_req is high.
fill_ack  input  1  fill complete; sampled only while fill_req is high.
inval  input  1  request to invalidate all entries.
busy  output  1  high in any state other than IDLE.
cmp_a  output  TAG_W  stored tag at the latched index; goes to comparator A0..A5.
cmp_b  output  TAG_W  latched request tag; goes to comparator B0..B5.
cmp_enb  output  1  valid bit of the latched index; goes to comparator ENB.
cmp_eq  input  1  comparator EQ, combinational in the same cycle.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - state = IDLE.
  - All valid bits are cleared in one cycle.
  - All outputs are 0, including req_ready.
  - Any pending invalidate is discarded.
  - Reset takes effect in any state, including mid-FILL. An outstanding fill_req drops, and a late fill_ack is ignored.
- req_ready = 1 only in IDLE with no pending invalidate.
- A request is accepted when req_valid & req_ready at edge T.
- The accepted index and tag are latched into request registers. These drive cmp_b, fill_addr and resp_index until the response.
- cmp_a and cmp_enb are asynchronous reads of the tag and valid arrays at the latched index.
- States:
  - IDLE:
    - If inval is set, or an invalidate is pending, go to FLUSH. Invalidate wins over a simultaneous req_valid.
    - Else if a request is accepted, go to CMP.
  - CMP (one cycle):
    - cmp_eq is sampled at the end of the cycle.
    - eq = 1: go to RESP with hit = 1.
    - eq = 0: go to FILL.
    - Because an invalid entry drives ENB = 0, an invalid entry always misses.
  - FILL:
    - fill_req is high.
    - On the edge where fill_ack = 1: write tag[idx] = latched tag, set valid[idx] = 1, go to RESP with hit = 0.
    - There is no timeout.
  - RESP (one cycle):
    - resp_valid = 1, resp_hit as determined, resp_index = latched index.
    - Next state is IDLE.
  - FLUSH:
    - A counter starts at 0 and clears valid[cnt] on each cycle.
    - After clearing entry 2**IDX_W-1 (32 cycles), return to IDLE.
    - The counter wraps to 0.
- Invalidate timing:
  - inval asserted outside IDLE sets a sticky pending flag. It is serviced on the next IDLE cycle.
  - Further inval pulses while a flush is pending or running are merged into it.
- Latency:
  - Hit: resp_valid in cycle T+2 (accept, CMP, RESP).
  - Miss: resp_valid in the cycle after the fill_ack edge.
- Throughput: one request outstanding at a time. The earliest next accept is the cycle after RESP.
- A fill_ack arriving outside FILL is ignored.

Optional Feature:
- Macro: TAG_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit over the tag.
  - In CMP, a parity mismatch forces the miss path, regardless of cmp_eq.
  - The entry is then refilled, and a sticky output perr (1 bit) is set.
  - perr is cleared only by reset.
- Undefined: no parity storage, no perr port; behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE, CMP, FILL, RESP, FLUSH (3-bit);
  - default IDX_W and TAG_W;
  - the address field split (index low, tag high).
- One sub-module, tag_match_store: tag/valid register array with async read, single write port, per-entry valid clear, and clear-all on reset.
- The FSM stays in tag_match_ctl.
- The comparator is instantiated outside this block.

Test Plan:
- After reset, request addr 0x2A5 (idx 5, tag 0x15) with the comparator model attached:
  - expect miss; fill_req high with fill_addr 0x2A5;
  - ack after 3 cycles; expect resp_valid with hit = 0 and index 5.
- Repeat addr 0x2A5: expect resp_valid at T+2 with hit = 1 and no fill_req.
- Request 0x3E5 (same idx 5, tag 0x1F): expect miss and fill. Then 0x2A5 misses again, because the tag was replaced.
- Assert inval together with req_valid in IDLE:
  - expect req_ready low and busy for 32 cycles;
  - then 0x3E5 misses.
- Pulse inval during FILL: fill completes and RESP is issued, then FLUSH starts; assert reset mid-FLUSH and verify all outputs are 0 the next cycle.
- With TAG_PARITY_EN: corrupt the parity of idx 5; lookup 0x2A5 gives a miss and fill, and perr = 1.
